// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline: memory wait, EX redirect, load-use.
// Also runs a memory-wait watchdog and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwe,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_flush,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WW-1:0]    wait_cnt_r;
    logic             load_use_s;
    logic             mem_stall_s;

    assign mem_stall_s = mem_req & ~mem_ack;
    assign load_use_s  = ex_is_load & ex_regwe & (ex_wreg != 5'd0) &
                         ((id_use_rs & (id_rs == ex_wreg)) |
                          (id_use_rt & (id_rt == ex_wreg)));

    // Prioritised enable/flush decode; a frozen or resetting pipeline drives everything low.
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst || (state_r == TIMEOUT)) begin
            pc_we = 1'b0;
        end else if (mem_stall_s) begin
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use_s) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
        end
    end

    // Watchdog FSM, sticky timeout flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            wait_cnt_r   <= {WW{1'b0}};
            err_timeout  <= 1'b0;
            stall_cycles <= {CNT_W{1'b0}};
        end else begin
            if (!pc_we && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles <= stall_cycles;
            end
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= {{(WW-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_r <= {WW{1'b0}};
                    end
                end
                MEM_WAIT: begin
                    // A dropped request counts as completion.
                    if (mem_ack || !mem_req) begin
                        state_r    <= RUN;
                        wait_cnt_r <= {WW{1'b0}};
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r     <= TIMEOUT;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
                    end
                end
                TIMEOUT: begin
                    state_r     <= TIMEOUT;
                    err_timeout <= 1'b1;
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= {WW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    // Control vector order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush
    localparam logic [6:0] C_NORM   = 7'b1101010;
    localparam logic [6:0] C_MEMS   = 7'b0000001;
    localparam logic [6:0] C_REDIR  = 7'b1111110;
    localparam logic [6:0] C_LU     = 7'b0001110;
    localparam logic [6:0] C_FROZEN = 7'b0000000;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_wreg;
    logic             id_use_rs, id_use_rt, ex_regwe, ex_is_load, ex_redirect, mem_req, mem_ack;
    logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct {
        logic [6:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_wreg(ex_wreg), .ex_regwe(ex_regwe), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
        .mem_wb_flush(mem_wb_flush), .err_timeout(err_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_wreg = 5'd0; ex_regwe = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic load_use_rs();
        ex_is_load = 1'b1; ex_regwe = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    // Inputs are already driven: queue the expectation, check controls mid-cycle, registers after the edge.
    task automatic cyc(input logic [6:0] ctrl, input logic err, input string tag);
        exp_t e;
        exp_t got;
        if (rst) exp_cnt = '0;
        else if (!ctrl[6] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        e.ctrl = ctrl; e.err = err; e.cnt = exp_cnt; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        checks++;
        assert ({pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush} === got.ctrl)
        else begin
            errors++;
            $error("FAIL %s ctrl got=%b exp=%b", got.tag,
                   {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}, got.ctrl);
        end
        @(posedge clk);
        #1;
        checks++;
        assert (err_timeout === got.err)
        else begin
            errors++;
            $error("FAIL %s err_timeout got=%b exp=%b", got.tag, err_timeout, got.err);
        end
        checks++;
        assert (stall_cycles === got.cnt)
        else begin
            errors++;
            $error("FAIL %s stall_cycles got=%0d exp=%0d", got.tag, stall_cycles, got.cnt);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc(C_FROZEN, 1'b0, "reset0");
        cyc(C_FROZEN, 1'b0, "reset1");

        // Load-use on rs and rt, and non-hazard variants
        idle(); cyc(C_NORM, 1'b0, "idle");
        load_use_rs(); cyc(C_LU, 1'b0, "lu_rs");
        idle(); cyc(C_NORM, 1'b0, "lu_release");
        load_use_rs(); ex_wreg = 5'd0; id_rs = 5'd0; cyc(C_NORM, 1'b0, "lu_r0");
        load_use_rs(); id_use_rs = 1'b0; cyc(C_NORM, 1'b0, "lu_nouse");
        load_use_rs(); ex_regwe = 1'b0; cyc(C_NORM, 1'b0, "lu_noregwe");
        idle(); ex_is_load = 1'b1; ex_regwe = 1'b1; ex_wreg = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
        cyc(C_LU, 1'b0, "lu_rt");

        // Memory wait: three stalled cycles then ack; ack on first cycle is no stall
        idle(); mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc(C_MEMS, 1'b0, "memwait");
        mem_ack = 1'b1; cyc(C_NORM, 1'b0, "mem_ack");
        idle(); cyc(C_NORM, 1'b0, "mem_after");
        mem_req = 1'b1; mem_ack = 1'b1; cyc(C_NORM, 1'b0, "mem_ack_first");

        // Priority: mem stall beats redirect and load-use; redirect wins on the ack cycle
        idle(); load_use_rs(); ex_redirect = 1'b1; mem_req = 1'b1;
        cyc(C_MEMS, 1'b0, "prio_mem");
        mem_ack = 1'b1; cyc(C_REDIR, 1'b0, "prio_ack_redir");
        mem_req = 1'b0; mem_ack = 1'b0; cyc(C_REDIR, 1'b0, "redir_over_lu");
        idle(); ex_redirect = 1'b1; cyc(C_REDIR, 1'b0, "redir_only");

        // Reset mid-wait clears the watchdog count
        idle(); mem_req = 1'b1;
        cyc(C_MEMS, 1'b0, "pre_rst_wait0");
        cyc(C_MEMS, 1'b0, "pre_rst_wait1");
        rst = 1'b1; cyc(C_FROZEN, 1'b0, "rst_midwait");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(C_MEMS, 1'b0, "wait_after_rst");

        // Fourth consecutive stalled edge trips the watchdog, then the pipeline stays frozen
        cyc(C_MEMS, 1'b1, "timeout_trip");
        idle(); cyc(C_FROZEN, 1'b1, "frozen_noreq");
        load_use_rs(); ex_redirect = 1'b1; cyc(C_FROZEN, 1'b1, "frozen_busy");
        idle(); mem_req = 1'b1; mem_ack = 1'b1; cyc(C_FROZEN, 1'b1, "frozen_ack");
        idle(); rst = 1'b1; cyc(C_FROZEN, 1'b0, "rst_timeout");
        idle(); cyc(C_NORM, 1'b0, "after_timeout_rst");

        // Saturation of the 4-bit stall counter
        load_use_rs();
        for (int i = 0; i < 20; i++) cyc(C_LU, 1'b0, "saturate");
        checks++;
        assert (stall_cycles === 4'd15)
        else begin
            errors++;
            $error("FAIL sat_final stall_cycles got=%0d exp=15", stall_cycles);
        end
        idle(); cyc(C_NORM, 1'b0, "sat_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
